// File: rtl/calc_core_if.sv
// Key-stream and display bundle between the keyboard scanner, calc_core and the display driver.
interface calc_core_if #(
    parameter int DIGITS = 4
);
    logic                  btn_press;
    logic                  is_num;
    logic                  is_op;
    logic                  is_eq;
    logic [3:0]            num_val;
    logic [1:0]            op_val;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic                  disp_neg;
    logic                  overflow;
    logic                  busy;
    logic                  done;

    modport master (
        output btn_press, is_num, is_op, is_eq, num_val, op_val,
        input  disp_bcd, disp_neg, overflow, busy, done
    );

    modport slave (
        input  btn_press, is_num, is_op, is_eq, num_val, op_val,
        output disp_bcd, disp_neg, overflow, busy, done
    );
endinterface

// File: rtl/calc_core.sv
// Calculator control: builds two BCD operands from key events, then a digit-serial BCD add/subtract.
// Result is valid (done) DIGITS+2 cycles after the "=" event; keys arriving while busy are dropped.
module calc_core #(
    parameter int DIGITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    calc_core_if.slave io
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, RESULT} state_t;

    state_t        r_state;
    logic          r_btn_q;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_r;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_y;
    logic [W-1:0]  r_disp;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_step;
    logic          r_sub;
    logic          r_swap;
    logic          r_neg;
    logic          r_ovf;
    logic          r_carry;
    logic          r_busy;
    logic          r_done;

    logic          w_key_evt;
    logic          w_dig_ok;
    logic          w_op_ok;
    logic          w_eq_ok;
    logic          w_cnt_room;
    logic [4:0]    w_sum;
    logic [4:0]    w_diff;
    logic [3:0]    w_digit;
    logic          w_cout;

    assign w_key_evt  = io.btn_press & ~r_btn_q;
    assign w_dig_ok   = w_key_evt & io.is_num & (io.num_val <= 4'd9);
    assign w_op_ok    = w_key_evt & io.is_op & ((io.op_val == 2'd1) || (io.op_val == 2'd2));
    assign w_eq_ok    = w_key_evt & io.is_eq;
    assign w_cnt_room = (r_cnt < CW'(DIGITS));

    // One BCD digit of the running add or subtract, LSD of r_x/r_y.
    always_comb begin
        w_sum   = {1'b0, r_x[3:0]} + {1'b0, r_y[3:0]} + {4'd0, r_carry};
        w_diff  = {1'b0, r_x[3:0]} - {1'b0, r_y[3:0]} - {4'd0, r_carry};
        w_digit = w_sum[3:0];
        w_cout  = 1'b0;
        if (r_sub) begin
            if (w_diff[4]) begin
                w_digit = w_diff[3:0] + 4'd10;
                w_cout  = 1'b1;
            end else begin
                w_digit = w_diff[3:0];
            end
        end else if (w_sum > 5'd9) begin
            w_digit = w_sum[3:0] + 4'd6;
            w_cout  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ENTER_A;
            r_btn_q <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_disp  <= '0;
            r_cnt   <= '0;
            r_step  <= '0;
            r_sub   <= 1'b0;
            r_swap  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_btn_q <= io.btn_press;
            r_done  <= 1'b0;

            case (r_state)
                ENTER_A:  r_disp <= r_a;
                ENTER_B:  r_disp <= r_b;
                CALC:     r_disp <= r_b;
                default:  r_disp <= r_r;
            endcase

            case (r_state)
                ENTER_A: begin
                    if (w_dig_ok) begin
                        if (w_cnt_room) begin
                            r_a   <= {r_a[W-5:0], io.num_val};
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_op_ok) begin
                        r_sub   <= (io.op_val == 2'd2);
                        r_b     <= '0;
                        r_cnt   <= '0;
                        r_state <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (w_dig_ok) begin
                        if (w_cnt_room) begin
                            r_b   <= {r_b[W-5:0], io.num_val};
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_op_ok) begin
                        r_sub <= (io.op_val == 2'd2);
                    end else if (w_eq_ok) begin
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (r_step == '0) begin
                        // Subtract always runs larger minus smaller; the sign is kept aside.
                        if (r_sub && (r_a < r_b)) begin
                            r_x    <= r_b;
                            r_y    <= r_a;
                            r_swap <= 1'b1;
                        end else begin
                            r_x    <= r_a;
                            r_y    <= r_b;
                            r_swap <= 1'b0;
                        end
                        r_carry <= 1'b0;
                        r_step  <= r_step + 1'b1;
                    end else begin
                        r_r     <= {w_digit, r_r[W-1:4]};
                        r_x     <= r_x >> 4;
                        r_y     <= r_y >> 4;
                        r_carry <= w_cout;
                        if (r_step == CW'(DIGITS)) begin
                            r_ovf   <= w_cout & ~r_sub;
                            r_neg   <= r_swap;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= RESULT;
                        end else begin
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_dig_ok) begin
                        r_a     <= {{(W-4){1'b0}}, io.num_val};
                        r_b     <= '0;
                        r_cnt   <= CW'(1);
                        r_ovf   <= 1'b0;
                        r_neg   <= 1'b0;
                        r_state <= ENTER_A;
                    end else if (w_op_ok && !r_neg && !r_ovf) begin
                        r_a     <= r_r;
                        r_sub   <= (io.op_val == 2'd2);
                        r_b     <= '0;
                        r_cnt   <= '0;
                        r_state <= ENTER_B;
                    end
                end
            endcase
        end
    end

    assign io.disp_bcd = r_disp;
    assign io.disp_neg = r_neg;
    assign io.overflow = r_ovf;
    assign io.busy     = r_busy;
    assign io.done     = r_done;
endmodule

// File: tb/tb_calc_core.sv
// Bench for calc_core: key-sequence vector table, hand-written timing/reset cases, random keys vs. a decimal model.
module tb_calc_core;
    localparam int D     = 4;
    localparam int K_NUM = 0;
    localparam int K_OP  = 1;
    localparam int K_EQ  = 2;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   done_cnt;
    int   done_cyc;
    int   busy_cnt;
    int   eq_cyc;

    calc_core_if #(.DIGITS(D)) io ();
    calc_core #(.DIGITS(D)) dut (.clk(clk), .rst(rst_n), .io(io));

    typedef struct {
        int          kind;
        logic [3:0]  val;
        logic [15:0] disp;
        logic        neg;
        logic        ovf;
    } vec_t;
    vec_t vt[$];

    int m_phase;   // 0 entering A, 1 entering B, 2 showing result
    int m_a, m_b, m_r, m_ndig;
    bit m_sub, m_neg, m_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (io.done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (io.busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] res;
        int t;
        t = v;
        for (int i = 0; i < D; i++) begin
            res[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return res;
    endfunction

    task automatic press(input int kind, input logic [3:0] val, input int hold, input int gap);
        @(negedge clk);
        io.is_num    = (kind == K_NUM);
        io.is_op     = (kind == K_OP);
        io.is_eq     = (kind == K_EQ);
        io.num_val   = val;
        io.op_val    = val[1:0];
        io.btn_press = 1'b1;
        if (kind == K_EQ) eq_cyc = cyc;
        repeat (hold) @(negedge clk);
        io.btn_press = 1'b0;
        io.is_num    = 1'b0;
        io.is_op     = 1'b0;
        io.is_eq     = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        io.btn_press = 1'b0;
        io.is_num    = 1'b0;
        io.is_op     = 1'b0;
        io.is_eq     = 1'b0;
        io.num_val   = 4'd0;
        io.op_val    = 2'd0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic model_key(input int kind, input int val);
        int lim;
        lim = 10 ** D;
        if (kind == K_NUM && val <= 9) begin
            if (m_phase == 0 && m_ndig < D) begin
                m_a = m_a * 10 + val; m_ndig++;
            end else if (m_phase == 1 && m_ndig < D) begin
                m_b = m_b * 10 + val; m_ndig++;
            end else if (m_phase == 2) begin
                m_a = val; m_b = 0; m_ndig = 1; m_neg = 0; m_ovf = 0; m_phase = 0;
            end
        end else if (kind == K_OP && (val == 1 || val == 2)) begin
            if (m_phase == 0) begin
                m_sub = (val == 2); m_b = 0; m_ndig = 0; m_phase = 1;
            end else if (m_phase == 1) begin
                m_sub = (val == 2);
            end else if (!m_neg && !m_ovf) begin
                m_a = m_r; m_sub = (val == 2); m_b = 0; m_ndig = 0; m_phase = 1;
            end
        end else if (kind == K_EQ && m_phase == 1) begin
            if (m_sub) begin
                m_neg = (m_a < m_b);
                m_r   = m_neg ? (m_b - m_a) : (m_a - m_b);
                m_ovf = 0;
            end else begin
                m_ovf = ((m_a + m_b) >= lim);
                m_r   = (m_a + m_b) % lim;
                m_neg = 0;
            end
            m_phase = 2;
        end
    endtask

    function automatic int model_disp();
        if (m_phase == 0) return m_a;
        if (m_phase == 1) return m_b;
        return m_r;
    endfunction

    initial begin
        int d0, b0, kind, val;
        cyc = 0; n_chk = 0; n_pass = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0; eq_cyc = 0;
        do_reset();
        chk("reset_disp", io.disp_bcd, 0);
        chk("reset_neg",  io.disp_neg, 0);
        chk("reset_ovf",  io.overflow, 0);
        chk("reset_busy", io.busy, 0);
        chk("reset_done", io.done, 0);

        vt.push_back('{K_NUM, 4'd1,  16'h0001, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd2,  16'h0012, 1'b0, 1'b0});
        vt.push_back('{K_OP,  4'd1,  16'h0000, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd3,  16'h0003, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd4,  16'h0034, 1'b0, 1'b0});
        vt.push_back('{K_EQ,  4'd0,  16'h0046, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd9,  16'h0009, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd9,  16'h0099, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd12, 16'h0099, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd9,  16'h0999, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd9,  16'h9999, 1'b0, 1'b0});
        vt.push_back('{K_OP,  4'd1,  16'h0000, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd1,  16'h0001, 1'b0, 1'b0});
        vt.push_back('{K_EQ,  4'd0,  16'h0000, 1'b0, 1'b1});
        vt.push_back('{K_OP,  4'd1,  16'h0000, 1'b0, 1'b1});
        vt.push_back('{K_NUM, 4'd7,  16'h0007, 1'b0, 1'b0});
        vt.push_back('{K_EQ,  4'd0,  16'h0007, 1'b0, 1'b0});
        vt.push_back('{K_OP,  4'd1,  16'h0000, 1'b0, 1'b0});
        vt.push_back('{K_EQ,  4'd0,  16'h0007, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd1,  16'h0001, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd2,  16'h0012, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd3,  16'h0123, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd4,  16'h1234, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd5,  16'h1234, 1'b0, 1'b0});
        vt.push_back('{K_OP,  4'd3,  16'h1234, 1'b0, 1'b0});
        vt.push_back('{K_OP,  4'd2,  16'h0000, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd5,  16'h0005, 1'b0, 1'b0});
        vt.push_back('{K_EQ,  4'd0,  16'h1229, 1'b0, 1'b0});
        vt.push_back('{K_OP,  4'd1,  16'h0000, 1'b0, 1'b0});
        vt.push_back('{K_OP,  4'd2,  16'h0000, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd1,  16'h0001, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd2,  16'h0012, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd2,  16'h0122, 1'b0, 1'b0});
        vt.push_back('{K_NUM, 4'd9,  16'h1229, 1'b0, 1'b0});
        vt.push_back('{K_EQ,  4'd0,  16'h0000, 1'b0, 1'b0});
        for (int i = 0; i < vt.size(); i++) begin
            press(vt[i].kind, vt[i].val, 8, 4);
            chk($sformatf("vec%0d_disp", i), io.disp_bcd, vt[i].disp);
            chk($sformatf("vec%0d_neg", i),  io.disp_neg, vt[i].neg);
            chk($sformatf("vec%0d_ovf", i),  io.overflow, vt[i].ovf);
        end

        // Latency, single done pulse and busy length for 12+34.
        do_reset();
        press(K_NUM, 4'd1, 8, 4);
        press(K_NUM, 4'd2, 8, 4);
        press(K_OP,  4'd1, 8, 4);
        press(K_NUM, 4'd3, 8, 4);
        press(K_NUM, 4'd4, 8, 4);
        d0 = done_cnt; b0 = busy_cnt;
        press(K_EQ, 4'd0, 8, 4);
        chk("lat_done_pulses", done_cnt - d0, 1);
        chk("lat_done_cycle",  done_cyc - eq_cyc, D + 2);
        chk("lat_busy_cycles", busy_cnt - b0, D + 1);
        chk("lat_disp", io.disp_bcd, 16'h0046);
        chk("lat_busy_after", io.busy, 0);

        // Long holds: one digit per press; 5-12 is negative, and a negative result does not chain.
        do_reset();
        press(K_NUM, 4'd5, 20, 4);  chk("hold_a", io.disp_bcd, 16'h0005);
        press(K_OP,  4'd2, 20, 4);
        press(K_NUM, 4'd1, 20, 4);  chk("hold_b1", io.disp_bcd, 16'h0001);
        press(K_NUM, 4'd2, 20, 4);  chk("hold_b2", io.disp_bcd, 16'h0012);
        press(K_EQ,  4'd0, 20, 4);
        chk("neg_disp", io.disp_bcd, 16'h0007);
        chk("neg_flag", io.disp_neg, 1);
        press(K_OP,  4'd1, 8, 4);
        chk("neg_nochain_disp", io.disp_bcd, 16'h0007);
        chk("neg_nochain_flag", io.disp_neg, 1);

        // Chaining, with a digit pressed while the second calculation runs.
        do_reset();
        press(K_NUM, 4'd8, 8, 4);
        press(K_OP,  4'd1, 8, 4);
        press(K_NUM, 4'd2, 8, 4);
        press(K_EQ,  4'd0, 8, 4);
        chk("chain_first", io.disp_bcd, 16'h0010);
        press(K_OP,  4'd2, 8, 4);
        press(K_NUM, 4'd3, 8, 4);
        d0 = done_cnt;
        press(K_EQ,  4'd0, 2, 0);
        press(K_NUM, 4'd6, 2, 12);
        chk("chain_second", io.disp_bcd, 16'h0007);
        chk("chain_neg", io.disp_neg, 0);
        chk("chain_done_pulses", done_cnt - d0, 1);

        // Reset pulled in the third CALC cycle.
        do_reset();
        press(K_NUM, 4'd1, 8, 4);
        press(K_OP,  4'd1, 8, 4);
        press(K_NUM, 4'd2, 8, 4);
        @(negedge clk);
        io.is_eq = 1'b1;
        io.btn_press = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midcalc_busy_before", io.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midcalc_disp", io.disp_bcd, 0);
        chk("midcalc_busy", io.busy, 0);
        chk("midcalc_done", io.done, 0);
        chk("midcalc_neg",  io.disp_neg, 0);
        chk("midcalc_ovf",  io.overflow, 0);
        io.btn_press = 1'b0;
        io.is_eq = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        press(K_NUM, 4'd4, 8, 4);
        chk("midcalc_after", io.disp_bcd, 16'h0004);
        press(K_OP,  4'd1, 8, 4);
        chk("midcalc_enter_b", io.disp_bcd, 16'h0000);

        // Random key stream against the decimal model.
        do_reset();
        m_phase = 0; m_a = 0; m_b = 0; m_r = 0; m_ndig = 0; m_sub = 0; m_neg = 0; m_ovf = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                kind = K_NUM; val = int'($urandom_range(0, 11));
            end else if (r < 82) begin
                kind = K_OP;  val = int'($urandom_range(0, 3));
            end else begin
                kind = K_EQ;  val = 0;
            end
            press(kind, 4'(val), int'($urandom_range(1, 6)), 8);
            model_key(kind, val);
            chk($sformatf("rnd%0d_disp", i), io.disp_bcd, to_bcd(model_disp()));
            chk($sformatf("rnd%0d_neg", i),  io.disp_neg, m_neg);
            chk($sformatf("rnd%0d_ovf", i),  io.overflow, m_ovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
